// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the test-memory request/response controller.
// Optional parity protection is enabled with the MEM_CTRL_PARITY_EN macro.
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } req_t;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_par(input logic [DATA_W_DEF-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Test-memory storage: synchronous write port, registered read port.
// With MEM_CTRL_PARITY_EN a parity bit is stored alongside each word.
// Storage is deliberately not reset; only the read register is.
module mem_ctrl_array
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef MEM_CTRL_PARITY_EN
   input  logic              wpar,
   output logic              rpar,
`endif
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Word write; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Read register holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

`ifdef MEM_CTRL_PARITY_EN
   logic mem_par [DEPTH];

   // Parity bit write, same timing as the data word.
   always_ff @(posedge clk) begin
      if (we) mem_par[addr] <= wpar;
   end

   // Parity bit read register, aligned with rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rpar <= 1'b0;
      else if (re) rpar <= mem_par[addr];
   end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Request/response controller for the 32 x 8 on-chip test memory.
// One request in flight; saturating write/read completion counters.
// MEM_CTRL_PARITY_EN adds err_inject, rsp_err and sticky parity_err.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | array write of the captured request
// READ  | array read into the response register
// RESP  | response presented, waiting for rsp_ready
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_CTRL_PARITY_EN
   input  logic              err_inject,
   output logic              rsp_err,
   output logic              parity_err,
`endif
   output logic              busy,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_WRITE = WRITE;
   localparam logic [1:0] S_READ  = READ;
   localparam logic [1:0] S_RESP  = RESP;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0] state;
   req_t       req_q;
   logic       we;
   logic       re;

   // rst_n gates ready so nothing is accepted while reset is held.
   assign req_ready = rst_n && (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign we        = (state == S_WRITE);
   assign re        = (state == S_READ);

   // Request capture and state sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         req_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_q <= '{write: req_write, addr: req_addr, data: req_wdata};
                  state <= req_write ? S_WRITE : S_READ;
               end
            end
            S_WRITE: state <= S_IDLE;
            S_READ:  state <= S_RESP;
            S_RESP:  if (rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Completion counters, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (we && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
         if (rsp_valid && rsp_ready && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
      end
   end

`ifdef MEM_CTRL_PARITY_EN
   logic inj_q;
   logic rpar;

   // Injection flag is sampled with the request, like the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        inj_q <= 1'b0;
      else if (state == S_IDLE && req_valid) inj_q <= err_inject;
   end

   assign rsp_err = rsp_valid && (even_par(rsp_rdata) != rpar);

   // Sticky error, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       parity_err <= 1'b0;
      else if (rsp_err) parity_err <= 1'b1;
   end
`endif

   mem_ctrl_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .re    (re),
      .addr  (req_q.addr),
      .wdata (req_q.data),
`ifdef MEM_CTRL_PARITY_EN
      .wpar  (even_par(req_q.data) ^ inj_q),
      .rpar  (rpar),
`endif
      .rdata (rsp_rdata)
   );

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// checked against an array/counter reference model. Counters built 4 bits wide.
module tb_mem_ctrl;

   localparam int AW   = 5;
   localparam int DW   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
`ifdef MEM_CTRL_PARITY_EN
   logic          err_inject = 1'b0;
   logic          rsp_err;
   logic          parity_err;
`endif

   mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
`ifdef MEM_CTRL_PARITY_EN
      .err_inject(err_inject),
      .rsp_err   (rsp_err),
      .parity_err(parity_err),
`endif
      .busy      (busy),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model
   logic [DW-1:0] mem_m [32];
   bit            known [32];
   bit            inj_m [32];
   int            wr_m = 0;
   int            rd_m = 0;
   bit            pe_m = 0;
   logic [DW-1:0] last_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All driving and sampling happens at the falling edge.
   task automatic do_write(input int a, input logic [DW-1:0] d, input bit inj);
      chk("wr_accept_ready", req_ready, 1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_wdata = d;
`ifdef MEM_CTRL_PARITY_EN
      err_inject = inj;
`endif
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0; req_wdata = DW'($urandom);
`ifdef MEM_CTRL_PARITY_EN
      err_inject = 1'b1;
`endif
      chk("wr_busy", busy, 1);
      chk("wr_ready_low", req_ready, 0);
      @(negedge clk);
`ifdef MEM_CTRL_PARITY_EN
      err_inject = 1'b0;
`endif
      mem_m[a] = d; known[a] = 1'b1; inj_m[a] = inj;
      if (wr_m < CMAX) wr_m++;
      chk("wr_cnt", wr_cnt, wr_m);
      chk("wr_idle", busy, 0);
   endtask

   task automatic do_read(input int a, input int stall);
      chk("rd_accept_ready", req_ready, 1);
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a);
      @(negedge clk);
      req_valid = 1'b0; req_addr = AW'($urandom);
      chk("rd_no_valid_in_read", rsp_valid, 0);
      chk("rd_busy", busy, 1);
      chk("rd_rdata_hold_prev", rsp_rdata, last_rdata);
      @(negedge clk);
      for (int i = 0; i <= stall; i++) begin
         rsp_ready = (i == stall);
         chk("rsp_valid", rsp_valid, 1);
         chk("req_ready_in_resp", req_ready, 0);
         if (known[a]) chk("rsp_rdata", rsp_rdata, mem_m[a]);
         if (i == 0) last_rdata = rsp_rdata;
         else        chk("rdata_stable", rsp_rdata, last_rdata);
         chk("rd_cnt_hold", rd_cnt, rd_m);
`ifdef MEM_CTRL_PARITY_EN
         if (known[a]) chk("rsp_err", rsp_err, inj_m[a]);
`endif
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      if (rd_m < CMAX) rd_m++;
      if (known[a] && inj_m[a]) pe_m = 1'b1;
      chk("rd_cnt", rd_cnt, rd_m);
      chk("rsp_done", rsp_valid, 0);
      chk("rdata_hold_after", rsp_rdata, last_rdata);
`ifdef MEM_CTRL_PARITY_EN
      chk("parity_err", parity_err, pe_m);
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin known[i] = 1'b0; inj_m[i] = 1'b0; mem_m[i] = '0; end

      // reset values
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_rd_cnt", rd_cnt, 0);
`ifdef MEM_CTRL_PARITY_EN
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_parity_err", parity_err, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);

      // zero-fill then pattern
      for (int i = 0; i < 5; i++) do_write(i, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) do_write(i, DW'(i), 1'b0);
      for (int i = 0; i < 5; i++) do_read(i, 0);
      chk("pattern_wr_cnt10", wr_cnt, 10);
      chk("pattern_rd_cnt5", rd_cnt, 5);

      // back-to-back write then read of the same word
      do_write(5, 8'hA5, 1'b0);
      do_read(5, 0);
      chk("b2b_rdata", rsp_rdata, 8'hA5);

      // response stall
      do_write(31, 8'h3C, 1'b0);
      do_read(31, 6);
      chk("stall_rdata", rsp_rdata, 8'h3C);

      // counter saturation: 20 writes
      for (int i = 0; i < 20; i++) do_write(6 + i, DW'($urandom), 1'b0);
      chk("wr_cnt_saturated", wr_cnt, CMAX);
      for (int i = 26; i < 31; i++) do_write(i, DW'($urandom), 1'b0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         int a;
         a = $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom), 1'b0);
         else                           do_read(a, $urandom_range(0, 3));
      end
      chk("rd_cnt_saturated", rd_cnt, CMAX);

      // reset while in READ
      chk("mid_rst_ready", req_ready, 1);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_rst_in_read", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_wr_cnt", wr_cnt, 0);
      chk("mid_rst_rd_cnt", rd_cnt, 0);
      chk("mid_rst_ready_low", req_ready, 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_still_idle", rsp_valid, 0);
      rst_n = 1'b1;
      wr_m = 0; rd_m = 0; pe_m = 1'b0; last_rdata = '0;
      @(negedge clk);
      chk("mid_rst_ready_back", req_ready, 1);
      chk("mid_rst_still_no_rsp", rsp_valid, 0);
      for (int i = 0; i < 6; i++) do_read(i, 0);
      do_read(31, 1);

`ifdef MEM_CTRL_PARITY_EN
      do_write(2, 8'h81, 1'b1);
      do_read(2, 0);
      chk("par_sticky_set", parity_err, 1);
      do_read(3, 0);
      chk("par_sticky_held", parity_err, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
